// File: rtl/spi_slave_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_slave_responder_if : SPI pins plus local parallel byte bus     |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
interface spi_slave_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SCLK;
    logic                  SS;
    logic                  MOSI;
    logic                  MISO_out;
    logic                  MISO_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  tx_underrun;
    logic                  frame_err;

    modport slave (
        input  SCLK, SS, MOSI, tx_data, tx_valid,
        output MISO_out, MISO_oe, tx_ready, rx_data, rx_valid,
               busy, tx_underrun, frame_err
    );

    modport master (
        output SCLK, SS, MOSI, tx_data, tx_valid,
        input  MISO_out, MISO_oe, tx_ready, rx_data, rx_valid,
               busy, tx_underrun, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_slave_responder : oversampled SPI mode-0 responder, MSB first  |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module spi_slave_responder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = 8'hFF
) (
    input  wire logic            clk,
    input  wire logic            rst,
    spi_slave_responder_if.slave spi
);
    localparam int                  c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_ss_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_sclk_prev;
    logic                    r_ss_prev;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic                    r_hold_full;
    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic                    r_reload;
    logic                    r_miso_out;
    logic                    r_miso_oe;
    logic                    r_busy;
    logic                    r_rx_valid;
    logic                    r_underrun;
    logic                    r_frame_err;

    logic                    w_sclk_s;
    logic                    w_ss_s;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_ss_fall;
    logic                    w_ss_rise;
    logic                    w_load;
    logic                    w_shift_tx;
    logic                    w_sample;
    logic                    w_end;
    logic                    w_abort;
    logic [DATA_WIDTH-1:0]   w_load_word;
    logic [DATA_WIDTH-1:0]   w_rx_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   spi.SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            r_sclk_prev <= w_sclk_s;
            r_ss_prev   <= w_ss_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk_s & ~r_sclk_prev;
    assign w_fall      = ~w_sclk_s & r_sclk_prev;
    assign w_ss_fall   = ~w_ss_s & r_ss_prev;
    assign w_ss_rise   = w_ss_s & ~r_ss_prev;
    assign w_load_word = r_hold_full ? r_hold : IDLE_WORD;
    assign w_rx_next   = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // SS rise takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift_tx   = 1'b0;
        w_sample     = 1'b0;
        w_end        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load       = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_next = ST_IDLE;
                    w_end        = 1'b1;
                    w_abort      = (r_bit_cnt != '0);
                end else if (w_rise) begin
                    w_sample = 1'b1;
                end else if (w_fall) begin
                    w_load     = r_reload;
                    w_shift_tx = ~r_reload;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_bit_cnt   <= '0;
            r_reload    <= 1'b0;
            r_miso_out  <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= w_abort;
            r_miso_oe   <= (w_state_next != ST_IDLE);
            r_busy      <= (w_state_next != ST_IDLE);

            if (w_load) begin
                r_tx_shift  <= w_load_word;
                r_miso_out  <= w_load_word[DATA_WIDTH-1];
                r_underrun  <= ~r_hold_full;
                r_hold_full <= 1'b0;
                r_reload    <= 1'b0;
                r_bit_cnt   <= '0;
            end else if (w_shift_tx) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                r_miso_out <= r_tx_shift[DATA_WIDTH-2];
            end

            // An accept in the same cycle as a load of an empty register refills it.
            if (spi.tx_valid && !r_hold_full) begin
                r_hold      <= spi.tx_data;
                r_hold_full <= 1'b1;
            end

            if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == c_LAST) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                    r_reload   <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (w_end) begin
                r_bit_cnt <= '0;
                r_reload  <= 1'b0;
            end
        end
    end

    assign spi.MISO_out    = r_miso_out;
    assign spi.MISO_oe     = r_miso_oe;
    assign spi.tx_ready    = ~r_hold_full;
    assign spi.rx_data     = r_rx_data;
    assign spi.rx_valid    = r_rx_valid;
    assign spi.busy        = r_busy;
    assign spi.tx_underrun = r_underrun;
    assign spi.frame_err   = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spi_slave_responder : scoreboard bench with a mode-0 master    |
// | Revision 1.0                                                       |
// +------------------------------------------------------------------+
module tb_spi_slave_responder;
    localparam int c_W    = 8;
    localparam int c_HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_responder_if #(.DATA_WIDTH(c_W)) u_bus ();

    spi_slave_responder #(
        .DATA_WIDTH (c_W),
        .SYNC_STAGES(2),
        .IDLE_WORD  (8'hFF)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .spi(u_bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_rxv    = 0;
    int n_unr    = 0;
    int n_ferr   = 0;
    logic [7:0] q_rx[$];
    logic [7:0] q_miso[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (u_bus.rx_valid) begin
                n_rxv++;
                if (q_rx.size() == 0) check("rx_unexpected", 32'(q_rx.size()), 32'd1);
                else check("rx_data", 32'(u_bus.rx_data), 32'(q_rx.pop_front()));
            end
            if (u_bus.tx_underrun) n_unr++;
            if (u_bus.frame_err) n_ferr++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        while (!u_bus.tx_ready && t < 200) begin
            tick(1);
            t++;
        end
        check("tx_ready_wait", 32'(u_bus.tx_ready), 32'd1);
        u_bus.tx_data  = d;
        u_bus.tx_valid = 1'b1;
        tick(1);
        u_bus.tx_valid = 1'b0;
        q_miso.push_back(d);
    endtask

    task automatic ss_start();
        u_bus.SS = 1'b0;
        tick(c_HALF);
    endtask

    // When last is set SCLK is left high so the frame closes before the final fall.
    task automatic spi_word(input logic [7:0] mo, input int nbits, input bit last);
        logic [7:0] cap = 8'h00;
        if (nbits == 8) q_rx.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
            u_bus.MOSI = mo[7-i];
            tick(c_HALF);
            u_bus.SCLK = 1'b1;
            cap = {cap[6:0], u_bus.MISO_out};
            tick(c_HALF);
            if (!(last && i == nbits - 1)) u_bus.SCLK = 1'b0;
        end
        if (nbits == 8) begin
            if (q_miso.size() == 0) check("miso_unexpected", 32'(q_miso.size()), 32'd1);
            else check("miso", 32'(cap), 32'(q_miso.pop_front()));
        end
    endtask

    task automatic ss_end();
        u_bus.SS = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("miso_oe_off", 32'(u_bus.MISO_oe), 32'd0);
        tick(c_HALF);
        u_bus.SCLK = 1'b0;
        tick(c_HALF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int rx0, unr0, ferr0;
        u_bus.SS       = 1'b1;
        u_bus.SCLK     = 1'b0;
        u_bus.MOSI     = 1'b0;
        u_bus.tx_data  = 8'h00;
        u_bus.tx_valid = 1'b0;
        #2 rst = 1'b0;
        tick(3);
        check("rst_tx_ready", 32'(u_bus.tx_ready), 32'd1);
        check("rst_oe",       32'(u_bus.MISO_oe),  32'd0);
        check("rst_busy",     32'(u_bus.busy),     32'd0);
        check("rst_rx_data",  32'(u_bus.rx_data),  32'd0);
        rst = 1'b1;
        tick(3);

        rx0 = n_rxv; unr0 = n_unr;
        push_tx(8'hCC);
        check("t1_ready_low", 32'(u_bus.tx_ready), 32'd0);
        ss_start();
        check("t1_ready_back", 32'(u_bus.tx_ready), 32'd1);
        check("t1_busy", 32'(u_bus.busy), 32'd1);
        check("t1_oe", 32'(u_bus.MISO_oe), 32'd1);
        spi_word(8'hAA, 8, 1'b1);
        ss_end();
        check("t1_rx_pulses", 32'(n_rxv - rx0), 32'd1);
        check("t1_underrun", 32'(n_unr - unr0), 32'd0);
        check("t1_rx_hold", 32'(u_bus.rx_data), 32'hAA);

        rx0 = n_rxv; unr0 = n_unr;
        push_tx(8'h3C);
        ss_start();
        fork
            begin
                spi_word(8'h12, 8, 1'b0);
                spi_word(8'h34, 8, 1'b1);
            end
            begin
                tick(40);
                push_tx(8'h81);
            end
        join
        ss_end();
        check("t2_rx_pulses", 32'(n_rxv - rx0), 32'd2);
        check("t2_underrun", 32'(n_unr - unr0), 32'd0);

        unr0 = n_unr;
        q_miso.push_back(8'hFF);
        ss_start();
        spi_word(8'h55, 8, 1'b1);
        ss_end();
        check("t3_underrun", 32'(n_unr - unr0), 32'd1);
        check("t3_rx_data", 32'(u_bus.rx_data), 32'h55);

        rx0 = n_rxv; ferr0 = n_ferr;
        ss_start();
        spi_word(8'h3B, 5, 1'b1);
        ss_end();
        check("t4_frame_err", 32'(n_ferr - ferr0), 32'd1);
        check("t4_no_rx", 32'(n_rxv - rx0), 32'd0);
        check("t4_rx_kept", 32'(u_bus.rx_data), 32'h55);
        push_tx(8'h96);
        q_miso.push_back(8'hFF);
        ss_start();
        spi_word(8'hA5, 8, 1'b0);
        spi_word(8'h5A, 8, 1'b1);
        ss_end();
        check("t4_ferr_once", 32'(n_ferr - ferr0), 32'd1);
        check("t4_rx_pulses", 32'(n_rxv - rx0), 32'd2);

        ss_start();
        spi_word(8'hC3, 4, 1'b1);
        check("t5_busy_pre", 32'(u_bus.busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t5_oe",       32'(u_bus.MISO_oe),     32'd0);
        check("t5_miso",     32'(u_bus.MISO_out),    32'd0);
        check("t5_busy",     32'(u_bus.busy),        32'd0);
        check("t5_tx_ready", 32'(u_bus.tx_ready),    32'd1);
        check("t5_rx_data",  32'(u_bus.rx_data),     32'd0);
        check("t5_rx_valid", 32'(u_bus.rx_valid),    32'd0);
        check("t5_underrun", 32'(u_bus.tx_underrun), 32'd0);
        check("t5_ferr",     32'(u_bus.frame_err),   32'd0);
        u_bus.SS   = 1'b1;
        u_bus.SCLK = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(4);
        q_miso.push_back(8'hFF);
        ss_start();
        spi_word(8'h0F, 8, 1'b1);
        ss_end();
        check("t5_rx_after", 32'(u_bus.rx_data), 32'h0F);

        unr0 = n_unr;
        push_tx(8'h11);
        u_bus.tx_data  = 8'h77;
        u_bus.tx_valid = 1'b1;
        tick(5);
        check("t6_ready_low", 32'(u_bus.tx_ready), 32'd0);
        u_bus.tx_valid = 1'b0;
        ss_start();
        spi_word(8'h99, 8, 1'b1);
        ss_end();
        check("t6_underrun", 32'(n_unr - unr0), 32'd0);

        tick(10);
        check("rx_queue_empty",   32'(q_rx.size()),   32'd0);
        check("miso_queue_empty", 32'(q_miso.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_responder.md
# spi_slave_responder

Standalone SPI responder (slave) for the serial link. It receives bytes from an external SPI initiator on MOSI and returns bytes from a one-deep transmit holding register on MISO. It runs SPI mode 0 (CPOL=0, CPHA=0), MSB first. It sits between the SPI pins and a local parallel byte interface, and oversamples the initiator's SCLK and SS with the system clock.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop depth of the SCLK/SS/MOSI synchronisers (≥2).
- IDLE_WORD, 8'hFF, word shifted out when the holding register is empty.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- SCLK  input  1  serial clock from initiator, asynchronous to clk.
- SS  input  1  active-low slave select from initiator.
- MOSI  input  1  serial data from initiator.
- MISO_out  output  1  serial data to initiator.
- MISO_oe  output  1  MISO drive enable; top level tri-states MISO when low.
- tx_data  input  DATA_WIDTH  word to transmit.
- tx_valid  input  1  tx_data offered.
- tx_ready  output  1  holding register empty; tx_valid accepted this cycle.
- rx_data  output  DATA_WIDTH  last complete received word.
- rx_valid  output  1  one-cycle pulse, rx_data newly updated.
- busy  output  1  frame in progress (synchronised SS low).
- tx_underrun  output  1  one-cycle pulse: IDLE_WORD loaded because holding register was empty.
- frame_err  output  1  one-cycle pulse: SS deasserted mid-word.

## Operation
- SCLK, SS and MOSI each pass through SYNC_STAGES flops. Rising and falling SCLK edges are detected from the last two synchronised samples. All logic is clocked by clk only.
- Holding register: a tx_valid && tx_ready cycle stores tx_data and drops tx_ready. A word load into the shift register empties it, and tx_ready rises the next cycle. tx_valid while tx_ready is low is ignored and the held word is kept.
- FSM states:
  - IDLE: MISO_oe=0, busy=0. Synchronised SS falling → LOAD.
  - LOAD (1 cycle): tx shift register ← holding word (or IDLE_WORD, pulsing tx_underrun). MISO_out ← MSB, MISO_oe=1, bit_cnt=0 → SHIFT.
  - SHIFT, on rising SCLK edge: rx shift ← {rx_shift[W-2:0], MOSI}, bit_cnt++.
    - On the DATA_WIDTH-th rising edge: rx_data ← completed word, rx_valid pulses, bit_cnt=0, reload flag set.
  - SHIFT, on falling SCLK edge:
    - If reload flag is set: load the next word exactly as in LOAD, drive its MSB, and clear the flag.
    - Otherwise shift tx left and drive the next bit.
  - SHIFT, synchronised SS rising: → IDLE.
    - If bit_cnt≠0, the partial word is discarded: no rx_valid, frame_err pulses.
    - If bit_cnt=0, there is no error. A word loaded by a reload but not yet shifted is lost and not returned to the holding register.
- SS rising and an SCLK edge detected in the same cycle: the SS rise wins and the edge is ignored.
- SCLK edges while in IDLE are ignored.
- Reset (rst low, asynchronous, any state): state=IDLE, MISO_out=0, MISO_oe=0, tx_ready=1, holding empty, rx_data=0, rx_valid=0, busy=0, tx_underrun=0, frame_err=0, bit_cnt=0, synchronisers cleared to SS=1, SCLK=0.

## Timing
- Input-to-detect latency: SYNC_STAGES+1 clk cycles from a pin edge to internal action.
- SCLK high and low phases must each last ≥ SYNC_STAGES+2 clk cycles. The minimum SCLK period is 8 clk for SYNC_STAGES=2. Bench uses 16.
- SS low to first SCLK rising edge must be ≥ SYNC_STAGES+3 clk cycles, so that the MSB is on MISO before it is sampled.
- MISO_out changes SYNC_STAGES+1 cycles after the SCLK falling edge. It is stable for the initiator's next rising-edge sample under the period rule above.
- rx_valid rises SYNC_STAGES+1 cycles after the last rising SCLK edge of a word.
- MISO_oe falls SYNC_STAGES+1 cycles after the SS pin rises.
- Back-to-back words with no SS gap are supported. A tx_data written before the falling edge that follows a word's last rising edge is used for the next word.

## Test plan
- Hold tx_data=0xCC; bench master sends 0xAA → rx_data=0xAA with a single rx_valid pulse; master captures 0xCC; tx_ready returns to 1 after LOAD.
- Load 0x3C, then load 0x81 during the first word; master sends 0x12,0x34 in one SS frame → rx_valid twice with 0x12 then 0x34; master captures 0x3C,0x81; no tx_underrun.
- No word loaded; master sends 0x55 → master captures 0xFF; tx_underrun pulses once in LOAD; rx_data=0x55.
- SS deasserted after 5 SCLK edges → no rx_valid, frame_err pulses once, MISO_oe low within 3 cycles. A following full frame 0xA5/0x5A transfers correctly.
- rst driven low mid-word (bit 4) → all outputs take reset values in the same cycle. After release and a new frame, 0x0F is received correctly and IDLE_WORD is returned.
- tx_valid held with 0x77 while tx_ready=0 (holding 0x11) → 0x77 is ignored; master captures 0x11.
